// File: rtl/pc.sv
// Program counter register for the single-cycle MIPS datapath.
// Ports: Clock, NReset (async, active-low), Current (next PC in), Address (PC out).
module pc #(
   parameter int unsigned           WIDTH       = 32,
   parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             Clock,
   input  logic             NReset,
   input  logic [WIDTH-1:0] Current,
   output logic [WIDTH-1:0] Address
);

   logic [WIDTH-1:0] r_pc;

   // Loads every edge; alignment and +4 math live in the datapath.
   always_ff @(posedge Clock or negedge NReset) begin
      if (!NReset) begin
         r_pc <= RESET_VALUE;
      end else begin
         r_pc <= Current;
      end
   end

   assign Address = r_pc;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed scenarios plus randomized run
// checked against a cycle-level reference of the PC register behaviour.
module tb_pc;

   localparam int unsigned      W  = 32;
   localparam logic [W-1:0]     RV = 32'h0000_0000;

   logic         Clock;
   logic         NReset;
   logic [W-1:0] Current;
   logic [W-1:0] Address;

   int checks;
   int failures;

   pc #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .Clock   (Clock),
      .NReset  (NReset),
      .Current (Current),
      .Address (Address)
   );

   initial Clock = 1'b0;
   always #10 Clock = ~Clock;

   task automatic test_reset();
      NReset  = 1'b0;
      Current = 32'h0000_0000;
      #1;
      checks++;
      if (Address !== RV) begin
         $display("FAIL reset_before_edge got=%h exp=%h", Address, RV);
         failures++;
      end
      @(posedge Clock); #1;
      checks++;
      if (Address !== RV) begin
         $display("FAIL reset_after_edge got=%h exp=%h", Address, RV);
         failures++;
      end
      Current = 32'hDEAD_BEEF;
      @(posedge Clock); #1;
      checks++;
      if (Address !== RV) begin
         $display("FAIL reset_ignores_current got=%h exp=%h", Address, RV);
         failures++;
      end
   endtask

   task automatic test_release_load();
      @(negedge Clock);
      NReset  = 1'b1;
      Current = 32'h0000_0004;
      #2;
      checks++;
      if (Address !== RV) begin
         $display("FAIL release_no_edge got=%h exp=%h", Address, RV);
         failures++;
      end
      @(posedge Clock); #1;
      checks++;
      if (Address !== 32'h0000_0004) begin
         $display("FAIL release_load4 got=%h exp=%h", Address, 32'h4);
         failures++;
      end
      @(negedge Clock);
      Current = 32'h0000_000C;
      @(posedge Clock); #1;
      checks++;
      if (Address !== 32'h0000_000C) begin
         $display("FAIL load_c got=%h exp=%h", Address, 32'hC);
         failures++;
      end
   endtask

   task automatic test_async_reset();
      @(negedge Clock);
      Current = 32'h0000_0008;
      @(posedge Clock); #1;
      checks++;
      if (Address !== 32'h0000_0008) begin
         $display("FAIL async_pre_load got=%h exp=%h", Address, 32'h8);
         failures++;
      end
      @(negedge Clock);
      #3;
      NReset  = 1'b0;
      Current = 32'h0000_0010;
      #1;
      checks++;
      if (Address !== RV) begin
         $display("FAIL async_immediate got=%h exp=%h", Address, RV);
         failures++;
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge Clock); #1;
         checks++;
         if (Address !== RV) begin
            $display("FAIL async_hold cyc=%0d got=%h exp=%h", i, Address, RV);
            failures++;
         end
      end
      @(negedge Clock);
      NReset  = 1'b1;
      Current = 32'h0000_0014;
      @(posedge Clock); #1;
      checks++;
      if (Address !== 32'h0000_0014) begin
         $display("FAIL async_resume got=%h exp=%h", Address, 32'h14);
         failures++;
      end
   endtask

   task automatic test_alternating();
      logic [W-1:0] curs [4];
      logic [W-1:0] last;
      curs[0] = 32'h4;
      curs[1] = 32'h8;
      curs[2] = 32'hC;
      curs[3] = 32'h10;
      last = Address;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         NReset  = (i % 2 == 0);
         Current = curs[i];
         #1;
         if (!NReset) last = RV;
         checks++;
         if (Address !== last) begin
            $display("FAIL alt_mid i=%0d got=%h exp=%h", i, Address, last);
            failures++;
         end
         @(posedge Clock); #1;
         last = NReset ? curs[i] : RV;
         checks++;
         if (Address !== last) begin
            $display("FAIL alt_edge i=%0d got=%h exp=%h", i, Address, last);
            failures++;
         end
      end
      @(negedge Clock);
      NReset = 1'b1;
   endtask

   task automatic test_no_leak();
      @(negedge Clock);
      NReset  = 1'b1;
      Current = 32'h0000_0020;
      @(posedge Clock); #1;
      Current = 32'h0000_0040;
      #2;
      checks++;
      if (Address !== 32'h0000_0020) begin
         $display("FAIL leak_high got=%h exp=%h", Address, 32'h20);
         failures++;
      end
      @(negedge Clock); #1;
      checks++;
      if (Address !== 32'h0000_0020) begin
         $display("FAIL leak_low got=%h exp=%h", Address, 32'h20);
         failures++;
      end
      @(posedge Clock); #1;
      checks++;
      if (Address !== 32'h0000_0040) begin
         $display("FAIL leak_next got=%h exp=%h", Address, 32'h40);
         failures++;
      end
   endtask

   task automatic test_full_width();
      logic [W-1:0] vals [3];
      logic [W-1:0] prev;
      vals[0] = 32'hFFFF_FFFC;
      vals[1] = 32'h8000_0000;
      vals[2] = 32'h0040_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         prev    = Address;
         Current = vals[i];
         #1;
         checks++;
         if (Address !== prev) begin
            $display("FAIL wide_early i=%0d got=%h exp=%h", i, Address, prev);
            failures++;
         end
         @(posedge Clock); #1;
         checks++;
         if (Address !== vals[i]) begin
            $display("FAIL wide_load i=%0d got=%h exp=%h", i, Address, vals[i]);
            failures++;
         end
      end
   endtask

   // Reference: PC is RESET_VALUE whenever reset is low, otherwise it is
   // the Current value seen at the most recent rising edge.
   task automatic test_random();
      logic [W-1:0] model;
      logic [W-1:0] cur;
      logic         rn;
      model = Address;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clock);
         rn  = ($urandom_range(7) != 0);
         cur = $urandom;
         if ($urandom_range(3) == 0) cur[1:0] = 2'b11;
         NReset  = rn;
         Current = cur;
         if (!rn) model = RV;
         #1;
         checks++;
         if (Address !== model) begin
            $display("FAIL rand_mid i=%0d got=%h exp=%h", i, Address, model);
            failures++;
         end
         @(posedge Clock);
         if (rn) model = cur;
         #1;
         checks++;
         if (Address !== model) begin
            $display("FAIL rand_edge i=%0d got=%h exp=%h", i, Address, model);
            failures++;
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      NReset   = 1'b0;
      Current  = '0;
      test_reset();
      test_release_load();
      test_async_reset();
      test_alternating();
      test_no_leak();
      test_full_width();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
